// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline boundary bundle: ID inputs, bypass sources, and the registered EX outputs.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic [XLEN-1:0]   rf_rdata1;
  logic [XLEN-1:0]   rf_rdata2;
  logic              mem_wen;
  logic [4:0]        mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              wb_wen;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              load_use_stall;
  logic [15:0]       bubble_cnt;

  modport slave (
    input  stall, flush, id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_ctrl,
           rf_rdata1, rf_rdata2, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data,
    output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
           load_use_stall, bubble_cnt
  );

  modport master (
    output stall, flush, id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_ctrl,
           rf_rdata1, rf_rdata2, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data,
    input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
           load_use_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand bypass, load-use hazard detection and
// a saturating bubble counter.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  logic              ex_valid_q;
  logic [XLEN-1:0]   ex_pc_q;
  logic [XLEN-1:0]   ex_op1_q;
  logic [XLEN-1:0]   ex_op2_q;
  logic [XLEN-1:0]   ex_imm_q;
  logic [4:0]        ex_rs1_q;
  logic [4:0]        ex_rs2_q;
  logic [4:0]        ex_rd_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [15:0]       bubble_q;

  logic [XLEN-1:0]   op1_sel;
  logic [XLEN-1:0]   op2_sel;
  logic              lu_hazard;

  // MEM is the younger producer, so it is checked before WB; x0 never bypasses
  always_comb begin
    op1_sel = bus.rf_rdata1;
    if (bus.id_rs1 != 5'd0) begin
      if (bus.mem_wen && (bus.mem_rd == bus.id_rs1))
        op1_sel = bus.mem_data;
      else if (bus.wb_wen && (bus.wb_rd == bus.id_rs1))
        op1_sel = bus.wb_data;
    end
  end

  always_comb begin
    op2_sel = bus.rf_rdata2;
    if (bus.id_rs2 != 5'd0) begin
      if (bus.mem_wen && (bus.mem_rd == bus.id_rs2))
        op2_sel = bus.mem_data;
      else if (bus.wb_wen && (bus.wb_rd == bus.id_rs2))
        op2_sel = bus.wb_data;
    end
  end

  assign lu_hazard = ex_valid_q && ex_ctrl_q[0] && (ex_rd_q != 5'd0) && bus.id_valid &&
                     ((ex_rd_q == bus.id_rs1) || (ex_rd_q == bus.id_rs2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_ctrl_q  <= '0;
      bubble_q   <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
    end else if (bus.stall) begin
      ex_valid_q <= ex_valid_q;
    end else if (lu_hazard) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      if (bubble_q != '1)
        bubble_q <= bubble_q + 16'd1;
    end else begin
      ex_valid_q <= bus.id_valid;
      ex_ctrl_q  <= bus.id_valid ? bus.id_ctrl : '0;
      ex_pc_q    <= bus.id_pc;
      ex_op1_q   <= op1_sel;
      ex_op2_q   <= op2_sel;
      ex_imm_q   <= bus.id_imm;
      ex_rs1_q   <= bus.id_rs1;
      ex_rs2_q   <= bus.id_rs2;
      ex_rd_q    <= bus.id_rd;
    end
  end

  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_pc          = ex_pc_q;
  assign bus.ex_op1         = ex_op1_q;
  assign bus.ex_op2         = ex_op2_q;
  assign bus.ex_imm         = ex_imm_q;
  assign bus.ex_rs1         = ex_rs1_q;
  assign bus.ex_rs2         = ex_rs2_q;
  assign bus.ex_rd          = ex_rd_q;
  assign bus.ex_ctrl        = ex_ctrl_q;
  assign bus.load_use_stall = lu_hazard;
  assign bus.bubble_cnt     = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver issues one stimulus per cycle and queues the
// expected EX state; a monitor pops and compares one cycle later.
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  logic clk;
  logic rst;

  id_ex_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    bit              do_reset;
    bit              force_ffe;
    logic            stall, flush, id_valid;
    logic [XLEN-1:0] pc, imm, rf1, rf2, mem_data, wb_data;
    logic [4:0]      rs1, rs2, rd, mem_rd, wb_rd;
    logic [15:0]     ctrl;
    logic            mem_wen, wb_wen;
  } stim_t;

  typedef struct {
    logic            valid;
    logic [XLEN-1:0] pc, op1, op2, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [15:0]     ctrl, bub;
    bit              known;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Newest producer with a matching non-zero destination supplies the operand
  function automatic logic [XLEN-1:0] pick(input stim_t s, input logic [4:0] rs,
                                           input logic [XLEN-1:0] rf);
    logic            wen [2];
    logic [4:0]      rd  [2];
    logic [XLEN-1:0] dat [2];
    wen[0] = s.mem_wen; rd[0] = s.mem_rd; dat[0] = s.mem_data;
    wen[1] = s.wb_wen;  rd[1] = s.wb_rd;  dat[1] = s.wb_data;
    if (rs == 5'd0) return rf;
    for (int i = 0; i < 2; i++)
      if (wen[i] && rd[i] == rs) return dat[i];
    return rf;
  endfunction

  task automatic reset_model();
    m = '{valid: 1'b0, pc: '0, op1: '0, op2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0,
          ctrl: '0, bub: '0, known: 1'b1};
  endtask

  task automatic step(input stim_t s);
    bit lus;
    @(negedge clk);
    bus.stall    = s.stall;    bus.flush    = s.flush;    bus.id_valid  = s.id_valid;
    bus.id_pc    = s.pc;       bus.id_imm   = s.imm;      bus.id_rs1    = s.rs1;
    bus.id_rs2   = s.rs2;      bus.id_rd    = s.rd;       bus.id_ctrl   = s.ctrl;
    bus.rf_rdata1 = s.rf1;     bus.rf_rdata2 = s.rf2;
    bus.mem_wen  = s.mem_wen;  bus.mem_rd   = s.mem_rd;   bus.mem_data  = s.mem_data;
    bus.wb_wen   = s.wb_wen;   bus.wb_rd    = s.wb_rd;    bus.wb_data   = s.wb_data;
    #1;
    if (s.do_reset) begin
      rst = 1'b0;
      #1;
      chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("rst_bubble",   {16'd0, bus.bubble_cnt}, 32'd0);
      chk("rst_ex_ctrl",  {16'd0, bus.ex_ctrl}, 32'd0);
      chk("rst_ex_pc",    bus.ex_pc, 32'd0);
      chk("rst_lus",      {31'd0, bus.load_use_stall}, 32'd0);
      rst = 1'b1;
      #1;
      chk("post_rst_lus", {31'd0, bus.load_use_stall}, 32'd0);
      reset_model();
    end
    if (s.force_ffe) begin
      force dut.bubble_q = 16'hFFFE;
      #1;
      release dut.bubble_q;
      m.bub = 16'hFFFE;
    end
    lus = m.valid && m.ctrl[0] && m.rd != 5'd0 && s.id_valid && (m.rd == s.rs1 || m.rd == s.rs2);
    chk("load_use_stall", {31'd0, bus.load_use_stall}, {31'd0, lus});
    if (s.flush) begin
      m.valid = 1'b0; m.ctrl = '0; m.known = 1'b0;
    end else if (s.stall) begin
      // registers hold
    end else if (lus) begin
      m.valid = 1'b0; m.ctrl = '0; m.known = 1'b0;
      if (m.bub != 16'hFFFF) m.bub = m.bub + 16'd1;
    end else begin
      m.valid = s.id_valid;
      m.ctrl  = s.id_valid ? s.ctrl : 16'd0;
      m.pc    = s.pc;  m.imm = s.imm;
      m.op1   = pick(s, s.rs1, s.rf1);
      m.op2   = pick(s, s.rs2, s.rf2);
      m.rs1   = s.rs1; m.rs2 = s.rs2; m.rd = s.rd;
      m.known = 1'b1;
    end
    q.push_back(m);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_valid",   {31'd0, bus.ex_valid}, {31'd0, e.valid});
      chk("ex_ctrl",    {16'd0, bus.ex_ctrl}, {16'd0, e.ctrl});
      chk("bubble_cnt", {16'd0, bus.bubble_cnt}, {16'd0, e.bub});
      if (e.known) begin
        chk("ex_pc",  bus.ex_pc,  e.pc);
        chk("ex_op1", bus.ex_op1, e.op1);
        chk("ex_op2", bus.ex_op2, e.op2);
        chk("ex_imm", bus.ex_imm, e.imm);
        chk("ex_rs1", {27'd0, bus.ex_rs1}, {27'd0, e.rs1});
        chk("ex_rs2", {27'd0, bus.ex_rs2}, {27'd0, e.rs2});
        chk("ex_rd",  {27'd0, bus.ex_rd},  {27'd0, e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst = 1'b0;
    s = idle();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0; bus.id_pc = '0; bus.id_imm = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.id_ctrl = '0;
    bus.rf_rdata1 = '0; bus.rf_rdata2 = '0; bus.mem_wen = 0; bus.mem_rd = '0;
    bus.mem_data = '0; bus.wb_wen = 0; bus.wb_rd = '0; bus.wb_data = '0;
    reset_model();
    #1;
    chk("init_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("init_bubble",   {16'd0, bus.bubble_cnt}, 32'd0);
    chk("init_lus",      {31'd0, bus.load_use_stall}, 32'd0);
    chk("init_ex_op1",   bus.ex_op1, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // bypass priority on op1, then x0 never bypasses on op2
    s = idle(); s.id_valid = 1; s.rs1 = 5; s.rf1 = 32'h11;
    s.mem_wen = 1; s.mem_rd = 5; s.mem_data = 32'h22; s.wb_wen = 1; s.wb_rd = 5; s.wb_data = 32'h33;
    step(s);
    s.mem_wen = 0; step(s);
    s.wb_wen = 0;  step(s);
    s = idle(); s.id_valid = 1; s.rs2 = 0; s.rf2 = 0; s.mem_wen = 1; s.mem_rd = 0; s.mem_data = 32'hDEAD;
    step(s);

    // load-use: load rd=7 in EX, consumer rs1=7 in ID
    s = idle(); s.id_valid = 1; s.ctrl = 16'h0003; s.rd = 7; s.pc = 32'h100;
    step(s);
    s = idle(); s.id_valid = 1; s.rs1 = 7; s.rd = 8; s.ctrl = 16'h0002; s.pc = 32'h104;
    step(s);
    step(s);

    // flush beats stall, then stall holds over three edges
    s = idle(); s.id_valid = 1; s.flush = 1; s.stall = 1; s.pc = 32'h200; s.ctrl = 16'h0002;
    step(s);
    s = idle(); s.id_valid = 1; s.pc = 32'h300; s.rd = 3; s.ctrl = 16'h0002; s.rf1 = 32'hABCD;
    step(s);
    s.stall = 1; s.pc = 32'h400; s.rd = 4;
    repeat (3) step(s);

    // saturation: preload 0xFFFE, then three bubbles
    s = idle(); s.force_ffe = 1; s.id_valid = 1; s.ctrl = 16'h0001; s.rd = 7;
    step(s);
    s = idle(); s.id_valid = 1; s.ctrl = 16'h0001; s.rd = 7; s.rs1 = 7;
    repeat (6) step(s);

    // reset with a valid load in EX and a pending bubble is discarded
    s = idle(); s.id_valid = 1; s.ctrl = 16'h0001; s.rd = 9;
    step(s);
    s = idle(); s.do_reset = 1; s.id_valid = 1; s.rs2 = 9; s.pc = 32'h500; s.rf2 = 32'h77;
    step(s);

    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.stall    = ($urandom_range(0, 9) == 0);
      s.flush    = ($urandom_range(0, 11) == 0);
      s.id_valid = ($urandom_range(0, 3) != 0);
      s.pc = $urandom; s.imm = $urandom; s.rf1 = $urandom; s.rf2 = $urandom;
      s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
      s.rd  = 5'($urandom_range(0, 7));
      s.ctrl = 16'($urandom);
      s.mem_wen = 1'($urandom); s.mem_rd = 5'($urandom_range(0, 7)); s.mem_data = $urandom;
      s.wb_wen  = 1'($urandom); s.wb_rd  = 5'($urandom_range(0, 7)); s.wb_data  = $urandom;
      s.do_reset = ($urandom_range(0, 99) == 0);
      step(s);
    end

    for (int w = 0; w < 4 && q.size() > 0; w++) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
